// File: rtl/fft_pkg.sv
// Shared state type and default frame geometry for the FFT butterfly controller.
package fft_pkg;
  localparam int NUM_STAGE = 9;
  localparam int BEATS     = 32;
  localparam int BF_LAT    = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fft_ctrl_state_t;
endpackage

// File: rtl/fft_vld_dly.sv
// Fixed DEPTH-cycle shift register for valid/last side-band bits.
// Latency DEPTH cycles; free-running, no backpressure.
module fft_vld_dly #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/fft_bfly_ctrl.sv
// Radix-2 FFT frame sequencer: loads BEATS beats, runs NUM_STAGE passes, drains BF_LAT.
// in_ready only while loading; FFT_BFLY_CTRL_LENCHK_EN enables in_last frame-length checking.
module fft_bfly_ctrl #(
  parameter int NUM_STAGE = fft_pkg::NUM_STAGE,
  parameter int BEATS     = fft_pkg::BEATS,
  parameter int BF_LAT    = fft_pkg::BF_LAT
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         bf_en,
  output logic [$clog2(NUM_STAGE)-1:0] stage_idx,
  output logic [$clog2(BEATS)-1:0]     beat_idx,
  output logic [$clog2(BEATS)-1:0]     tw_addr,
  output logic                         out_valid,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err_len
);
  import fft_pkg::*;

  localparam int SW = $clog2(NUM_STAGE);
  localparam int BW = $clog2(BEATS);
  localparam int DW = $clog2(BF_LAT + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGE - 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(BF_LAT - 1);

  fft_ctrl_state_t state;
  logic [DW-1:0]   drain_cnt;
  logic            accept;
  logic            last_beat;
  logic            last_stage;
  logic            len_bad;
  logic [1:0]      dly_d;
  logic [1:0]      dly_q;

  // Gating with rstn keeps in_ready low throughout reset even though IDLE is the reset state.
  assign in_ready   = rstn && ((state == ST_IDLE) || (state == ST_LOAD));
  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_idx == LAST_BEAT);
  assign last_stage = (stage_idx == LAST_STAGE);
  assign bf_en      = (state == ST_RUN);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  // BW-bit shift truncation is the mod BEATS, since BEATS is a power of two.
  assign tw_addr    = bf_en ? (beat_idx << stage_idx) : '0;

`ifdef FFT_BFLY_CTRL_LENCHK_EN
  // beat_idx is 0 in IDLE, so last_beat alone marks the frame's final position.
  assign len_bad = accept && (in_last != last_beat);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        err_len <= 1'b0;
    else if (len_bad) err_len <= 1'b1;
  end
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign len_bad        = 1'b0;
  assign err_len        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      stage_idx <= '0;
      beat_idx  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            if (len_bad) begin
              state    <= ST_IDLE;
              beat_idx <= '0;
            end else if (last_beat) begin
              state     <= ST_RUN;
              beat_idx  <= '0;
              stage_idx <= '0;
            end else begin
              state    <= ST_LOAD;
              beat_idx <= beat_idx + BW'(1);
            end
          end
        end
        ST_RUN: begin
          beat_idx <= beat_idx + BW'(1);
          if (last_beat) begin
            if (last_stage) begin
              state     <= ST_DRAIN;
              stage_idx <= '0;
              drain_cnt <= '0;
            end else begin
              stage_idx <= stage_idx + SW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) state <= ST_DONE;
          else                         drain_cnt <= drain_cnt + DW'(1);
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dly_d = {bf_en && last_stage && last_beat, bf_en && last_stage};

  fft_vld_dly #(
    .W     (2),
    .DEPTH (BF_LAT)
  ) u_vld_dly (
    .clk  (clk),
    .rstn (rstn),
    .d    (dly_d),
    .q    (dly_q)
  );

  assign out_valid = dly_q[0];
  assign out_last  = dly_q[1];
endmodule
